// File: rtl/stim_gen.sv
// Pseudo-random stimulus generator driving a data vector and select bit for a downstream selector.
// Optional feature: define STIM_GEN_X_INJECT_EN to drive x on a_o bits whose nibble is 2 or 3.
module stim_gen #(
    parameter int          N      = 8,
    parameter logic [31:0] S      = 32'd20000,
    parameter int          PERIOD = 2,
    parameter logic [63:0] SEED   = 64'h0123_4567_89AB_CDEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    output logic [N-1:0] a_o,
    output logic         sel_o,
    output logic         valid_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [31:0]  count_o
);

    localparam int          STEPS    = 4 * (N + 1);
    localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;
    localparam logic [7:0]  RELOAD   = 8'(PERIOD - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [7:0]   timer;
    logic [63:0]  lfsr;
    logic [63:0]  lfsr_adv;
    logic [N-1:0] a_next;
    logic         sel_next;
    logic [31:0]  count_inc;

    function automatic logic nib_bit(input logic [3:0] nib);
`ifdef STIM_GEN_X_INJECT_EN
        if (nib >= 4'd10)
            return 1'b1;
        else if (nib == 4'd2 || nib == 4'd3)
            return 1'bx;
        else
            return 1'b0;
`else
        return (nib >= 4'd10);
`endif
    endfunction

    // Each vector consumes one fresh nibble per output bit, so the LFSR is unrolled a full nibble set per vector.
    always_comb begin
        lfsr_adv = lfsr;
        for (int k = 0; k < STEPS; k++)
            lfsr_adv = {lfsr_adv[62:0], lfsr_adv[63] ^ lfsr_adv[62] ^ lfsr_adv[60] ^ lfsr_adv[59]};
        a_next = '0;
        for (int i = 0; i < N; i++)
            a_next[i] = nib_bit(lfsr_adv[4*i +: 4]);
        sel_next = (lfsr_adv[4*N +: 4] >= 4'd10);
    end

    assign count_inc = count_o + 32'd1;
    assign busy_o    = (state == RUN);
    assign done_o    = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            timer   <= 8'd0;
            lfsr    <= SEED_EFF;
            a_o     <= '0;
            sel_o   <= 1'b0;
            valid_o <= 1'b0;
            count_o <= 32'd0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        count_o <= 32'd0;
                        timer   <= RELOAD;
                        state   <= (S == 32'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else begin
                        lfsr    <= lfsr_adv;
                        a_o     <= a_next;
                        sel_o   <= sel_next;
                        valid_o <= 1'b1;
                        count_o <= count_inc;
                        timer   <= RELOAD;
                        if (count_inc == S)
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stim_gen.sv
// Scoreboard bench for stim_gen: four instances cover short runs, S=0, PERIOD=1 and the default long run.
// Expected vectors come from a bench LFSR model pushed at start time and popped on valid_o.
module tb_stim_gen;

    localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

    logic clk;
    logic rst;
    logic start_a, start_z, start_p, start_d;

    logic [7:0]  a_a;  logic sel_a, valid_a, busy_a, done_a;  logic [31:0] count_a;
    logic [7:0]  a_z;  logic sel_z, valid_z, busy_z, done_z;  logic [31:0] count_z;
    logic [3:0]  a_p;  logic sel_p, valid_p, busy_p, done_p;  logic [31:0] count_p;
    logic [7:0]  a_d;  logic sel_d, valid_d, busy_d, done_d;  logic [31:0] count_d;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] model_a, model_p, model_d;
    logic [16:0] q_a[$];
    logic [16:0] q_p[$];
    logic [16:0] q_d[$];

    int z_valid_seen = 0;
    int ones_cnt     = 0;
    int bit_cnt      = 0;
    int x_cnt        = 0;
    int a_bit_cnt    = 0;
    int sel_x_cnt    = 0;
    int d_vec_idx    = 0;
    int d_run        = 0;
    logic [16:0] d_run1_vec1, d_run2_vec1;

    stim_gen #(.N(8), .S(32'd4), .PERIOD(2), .SEED(SEED)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .a_o(a_a), .sel_o(sel_a),
        .valid_o(valid_a), .busy_o(busy_a), .done_o(done_a), .count_o(count_a));

    stim_gen #(.N(8), .S(32'd0), .PERIOD(2), .SEED(SEED)) dut_z (
        .clk_i(clk), .rst_i(rst), .start_i(start_z), .a_o(a_z), .sel_o(sel_z),
        .valid_o(valid_z), .busy_o(busy_z), .done_o(done_z), .count_o(count_z));

    stim_gen #(.N(4), .S(32'd6), .PERIOD(1), .SEED(64'h0)) dut_p (
        .clk_i(clk), .rst_i(rst), .start_i(start_p), .a_o(a_p), .sel_o(sel_p),
        .valid_o(valid_p), .busy_o(busy_p), .done_o(done_p), .count_o(count_p));

    stim_gen dut_d (
        .clk_i(clk), .rst_i(rst), .start_i(start_d), .a_o(a_d), .sel_o(sel_d),
        .valid_o(valid_d), .busy_o(busy_d), .done_o(done_d), .count_o(count_d));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] advance(input logic [63:0] s, input int n);
        for (int k = 0; k < 4 * (n + 1); k++)
            s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        return s;
    endfunction

    function automatic logic nib_value(input logic [3:0] nib);
`ifdef STIM_GEN_X_INJECT_EN
        if (nib >= 4'd10) return 1'b1;
        if (nib == 4'd2 || nib == 4'd3) return 1'bx;
        return 1'b0;
`else
        return (nib >= 4'd10);
`endif
    endfunction

    // Packed as {sel, zero-padded a} so every instance width fits one queue type.
    function automatic logic [16:0] vec_of(input logic [63:0] s, input int n);
        logic [16:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v[i] = nib_value(s[4*i +: 4]);
        v[16] = (s[4*n +: 4] >= 4'd10);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which);
        case (which)
            0: begin
                start_a = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    model_a = advance(model_a, 8);
                    q_a.push_back(vec_of(model_a, 8));
                end
            end
            1: start_z = 1'b1;
            2: begin
                start_p = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    model_p = advance(model_p, 4);
                    q_p.push_back(vec_of(model_p, 4));
                end
            end
            default: begin
                start_d = 1'b1;
                for (int k = 0; k < 20000; k++) begin
                    model_d = advance(model_d, 8);
                    q_d.push_back(vec_of(model_d, 8));
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetModels();
        model_a = SEED;
        model_p = 64'h1;
        model_d = SEED;
        q_a.delete();
        q_p.delete();
        q_d.delete();
        d_vec_idx = 0;
    endtask

    always @(negedge clk) begin
        if (valid_a) begin
            if (q_a.size() == 0) checkOutput("a_unexpected_valid", 1, 0);
            else checkOutput("a_vector", {47'd0, sel_a, 8'd0, a_a}, {47'd0, q_a.pop_front()});
        end
        if (valid_z) z_valid_seen++;
        if (valid_p) begin
            if (q_p.size() == 0) checkOutput("p_unexpected_valid", 1, 0);
            else checkOutput("p_vector", {47'd0, sel_p, 12'd0, a_p}, {47'd0, q_p.pop_front()});
        end
        if (valid_d) begin
            d_vec_idx++;
            if (d_vec_idx == 1 && d_run == 1) d_run1_vec1 = {sel_d, 8'd0, a_d};
            if (d_vec_idx == 1 && d_run == 2) d_run2_vec1 = {sel_d, 8'd0, a_d};
            for (int i = 0; i < 8; i++) begin
                if (a_d[i] === 1'b1) ones_cnt++;
                if ($isunknown(a_d[i])) x_cnt++;
            end
            if (sel_d === 1'b1) ones_cnt++;
            if ($isunknown(sel_d)) sel_x_cnt++;
            bit_cnt   += 9;
            a_bit_cnt += 8;
            if (q_d.size() == 0) checkOutput("d_unexpected_valid", 1, 0);
            else checkOutput("d_vector", {47'd0, sel_d, 8'd0, a_d}, {47'd0, q_d.pop_front()});
        end
    end

    initial begin
        int wait_i;
        start_a = 1'b0; start_z = 1'b0; start_p = 1'b0; start_d = 1'b0;
        rst = 1'b1;
        resetModels();
        tick();
        tick();
        rst = 1'b0;

        for (int c = 0; c < 100; c++) begin
            tick();
            checkOutput("idle_outputs", {20'd0, a_d, sel_d, valid_d, busy_d, done_d, count_d}, 64'd0);
        end

        // Short run with a start pulse during RUN that must be ignored.
        applyStimulus(0);
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput("a_valid", valid_a, (k % 2 == 0));
            checkOutput("a_count", count_a, k / 2);
            checkOutput("a_done", done_a, (k == 8));
            checkOutput("a_busy", busy_a, (k < 8));
            start_a = (k == 3);
        end
        start_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("a_done_hold", {valid_a, done_a, count_a}, {1'b0, 1'b1, 32'd4});
        end

        applyStimulus(0);
        tick();
        start_a = 1'b0;
        checkOutput("a_restart_count", count_a, 0);
        checkOutput("a_restart_busy", busy_a, 1);
        for (int k = 0; k < 8; k++) tick();
        checkOutput("a_rerun_done", {done_a, count_a}, {1'b1, 32'd4});

        applyStimulus(1);
        tick();
        start_z = 1'b0;
        checkOutput("z_done", done_z, 1);
        checkOutput("z_busy", busy_z, 0);
        checkOutput("z_count", count_z, 0);
        for (int k = 0; k < 5; k++) tick();

        applyStimulus(2);
        tick();
        start_p = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput("p_valid", valid_p, 1);
            checkOutput("p_count", count_p, k);
            checkOutput("p_done", done_p, (k == 6));
        end
        tick();
        checkOutput("p_valid_after", valid_p, 0);

        // Abort the long run at vector 5, then restart from the reseeded LFSR.
        d_run = 1;
        applyStimulus(3);
        tick();
        start_d = 1'b0;
        for (wait_i = 0; wait_i < 100 && count_d != 32'd5; wait_i++) tick();
        checkOutput("d_reach_vec5", count_d, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("d_reset_outputs", {20'd0, a_d, sel_d, valid_d, busy_d, done_d, count_d}, 64'd0);
        resetModels();
        for (int k = 0; k < 5; k++) tick();
        checkOutput("d_aborted", {valid_d, busy_d, count_d}, 0);

        d_run = 2;
        applyStimulus(3);
        tick();
        start_d = 1'b0;
        for (wait_i = 0; wait_i < 50000 && !done_d; wait_i++) tick();
        checkOutput("d_done", done_d, 1);
        checkOutput("d_count", count_d, 20000);
        tick();
        checkOutput("d_queue_drained", q_d.size(), 0);
        checkOutput("d_restart_vec1", {47'd0, d_run2_vec1}, {47'd0, d_run1_vec1});
        checkOutput("d_ones_fraction_ok",
                    (ones_cnt * 1000 / bit_cnt >= 355) && (ones_cnt * 1000 / bit_cnt <= 395), 1);
        checkOutput("d_sel_never_x", sel_x_cnt, 0);
`ifdef STIM_GEN_X_INJECT_EN
        checkOutput("d_x_fraction_ok",
                    (x_cnt * 1000 / a_bit_cnt >= 115) && (x_cnt * 1000 / a_bit_cnt <= 135), 1);
`else
        checkOutput("d_no_x", x_cnt, 0);
`endif
        checkOutput("z_valid_never", z_valid_seen, 0);
        checkOutput("a_queue_drained", q_a.size(), 0);
        checkOutput("p_queue_drained", q_p.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stim_gen.md
STIM_GEN -- requirements
Module: stim_gen

Interface
REQ-001 SHALL have parameter N, default 8, data width; legal range 1..15.
REQ-002 SHALL have parameter S, default 20000, vectors per run; legal range 0..2^32-1.
REQ-003 SHALL have parameter PERIOD, default 2, clock cycles per vector; legal range 1..255.
REQ-004 SHALL have parameter SEED, default 64'h0123_4567_89AB_CDEF, LFSR start value; a zero SEED is replaced by 64'h1.
REQ-005 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start_i, input, 1, run request, sampled in IDLE and DONE.
REQ-008 SHALL have port a_o, output, N, stimulus data vector for the downstream selector's data input.
REQ-009 SHALL have port sel_o, output, 1, stimulus select bit for the downstream selector.
REQ-010 SHALL have port valid_o, output, 1, one-cycle pulse marking a new vector.
REQ-011 SHALL have port busy_o, output, 1, high while in RUN.
REQ-012 SHALL have port done_o, output, 1, high while in DONE.
REQ-013 SHALL have port count_o, output, 32, vectors emitted in the current run.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE or DONE with start_i=1, enter RUN, clear count_o and load timer=PERIOD-1; if S=0, go directly to DONE instead.
REQ-016 SHALL, in RUN, decrement the timer on every edge while it is nonzero; when it is 0, emit one vector and reload timer=PERIOD-1.
REQ-017 SHALL place the first vector PERIOD edges after the start edge, then one vector every PERIOD edges.
REQ-018 SHALL emit a vector as follows, all on the same edge: advance the LFSR by 4*(N+1) steps (combinational unroll), update a_o and sel_o, pulse valid_o for one cycle, increment count_o.
REQ-019 SHALL use a 64-bit Fibonacci LFSR: shift left; new bit0 = bit63^bit62^bit60^bit59.
REQ-020 SHALL derive output bits from nibble k = post-advance LFSR bits [4k+3:4k]: a_o[i] = (nibble i >= 10); sel_o = (nibble N >= 10), giving P(1) = 6/16.
REQ-021 SHALL go from RUN to DONE on the edge that emits vector S (count_o = S).
REQ-022 SHALL hold a_o and sel_o between vectors and in IDLE and DONE.
REQ-023 SHALL ignore start_i while in RUN.
REQ-024 SHALL, on a start_i in DONE, restart with count_o cleared and the LFSR continuing from its current state (not reseeded).
REQ-025 SHALL emit a vector on every RUN edge when PERIOD=1.

Reset
REQ-026 SHALL, on any edge with rst_i=1, reset to state IDLE, LFSR=SEED (or 64'h1), a_o=0, sel_o=0, valid_o=0, busy_o=0, done_o=0, count_o=0, timer=0.
REQ-027 SHALL give rst_i priority over start_i; reset during RUN aborts the run with no further vectors.

Configuration
REQ-028 SHALL, when macro STIM_GEN_X_INJECT_EN is defined, drive a_o[i] = 1'bx for nibble values 2..3, 1 for >= 10 and 0 otherwise; sel_o SHALL never be x.
REQ-029 SHALL, when STIM_GEN_X_INJECT_EN is undefined, drive only 0 and 1 on a_o, per REQ-020.

Verification
REQ-030 Reset, start_i=0 for 100 cycles -> a_o=0, sel_o=0, valid_o, busy_o and done_o all 0 throughout.
REQ-031 N=8, S=4, PERIOD=2, start_i pulse sampled at edge 10 -> valid_o at edges 12, 14, 16, 18; count_o steps 1..4; done_o=1 and busy_o=0 from edge 18.
REQ-032 S=0, start_i pulse -> done_o=1 on the next edge, valid_o never asserted, count_o=0.
REQ-033 Default parameters, 20000 vectors checked against a bench LFSR model -> every a_o and sel_o bit matches; fraction of ones 0.375 +/- 0.02.
REQ-034 rst_i pulse at vector 5, then restart -> outputs at reset values on the next edge; vector 1 after restart equals vector 1 of the first run.
REQ-035 STIM_GEN_X_INJECT_EN defined, 20000 vectors -> fraction of x on a_o bits 0.125 +/- 0.01; sel_o never x; with macro undefined -> zero x.
